// File: rtl/rf_alu_unit_if.sv
`default_nettype none
// rf_alu_unit_if: decode/writeback-side bundle for the register file + ALU execute core.
// Revision: 1.0
interface rf_alu_unit_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
);
   logic [IDX_W-1:0]  readReg1;
   logic [IDX_W-1:0]  readReg2;
   logic [IDX_W-1:0]  writeReg;
   logic [DATA_W-1:0] writeData;
   logic              write;
   logic              alu_src;
   logic [DATA_W-1:0] imm;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] readData1;
   logic [DATA_W-1:0] readData2;
   logic [DATA_W-1:0] result;
   logic              zero;

   modport master (
      output readReg1, readReg2, writeReg, writeData, write, alu_src, imm, alu_op,
      input  readData1, readData2, result, zero
   );

   modport slave (
      input  readReg1, readReg2, writeReg, writeData, write, alu_src, imm, alu_op,
      output readData1, readData2, result, zero
   );
endinterface
`default_nettype wire

// File: rtl/rf_alu_unit.sv
`default_nettype none
// rf_alu_unit: 32x32 register file (2R/1W, x0 hardwired to zero) feeding a combinational RV32I ALU.
// Revision: 1.0
module rf_alu_unit #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 32
) (
   input  wire             clk,
   input  wire             rst,
   rf_alu_unit_if.slave    bus
);
   localparam int IDX_W = $clog2(NREGS);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] op1_w;
   logic [DATA_W-1:0] op2_w;
   logic [4:0]        shamt_w;
   logic [DATA_W-1:0] result_w;

   // Index 0 is never written, so it keeps its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (bus.write && (bus.writeReg != '0)) begin
         regs_q[bus.writeReg] <= bus.writeData;
      end
   end

   always_comb begin
      bus.readData1 = (bus.readReg1 == '0) ? '0 : regs_q[bus.readReg1];
      bus.readData2 = (bus.readReg2 == '0) ? '0 : regs_q[bus.readReg2];
   end

   assign op1_w   = bus.readData1;
   assign op2_w   = bus.alu_src ? bus.imm : bus.readData2;
   assign shamt_w = op2_w[4:0];

   always_comb begin
      result_w = '0;
      case (bus.alu_op)
         ALU_AND: result_w = op1_w & op2_w;
         ALU_OR:  result_w = op1_w | op2_w;
         ALU_ADD: result_w = op1_w + op2_w;
         ALU_SUB: result_w = op1_w - op2_w;
         ALU_SLT: result_w = {{(DATA_W-1){1'b0}}, ($signed(op1_w) < $signed(op2_w))};
         ALU_SRL: result_w = op1_w >> shamt_w;
         ALU_SLL: result_w = op1_w << shamt_w;
         ALU_SRA: result_w = $unsigned($signed(op1_w) >>> shamt_w);
         ALU_XOR: result_w = op1_w ^ op2_w;
         default: result_w = '0;
      endcase
   end

   assign bus.result = result_w;
   assign bus.zero   = (result_w == '0);
endmodule
`default_nettype wire

// File: tb/tb_rf_alu_unit.sv
`default_nettype none
// tb_rf_alu_unit: directed and randomized checks of the register file + ALU against a behavioural model.
// Revision: 1.0
module tb_rf_alu_unit;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [31:0] mregs [32];

   rf_alu_unit_if #(.DATA_W(32), .IDX_W(5)) bus ();

   rf_alu_unit #(.DATA_W(32), .NREGS(32)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      sh = b % 32;
      case (op)
         4'd0:  return a & b;
         4'd1:  return a | b;
         4'd2:  return a + b;
         4'd6:  return a - b;
         4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd8:  return a >> sh;
         4'd9:  return a << sh;
         4'd10: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         4'd13: return a ^ b;
         default: return 32'h0;
      endcase
   endfunction

   // Write a register through one clock edge and mirror it in the model.
   task automatic wr(input logic [4:0] idx, input logic [31:0] data);
      bus.write = 1'b1; bus.writeReg = idx; bus.writeData = data;
      @(posedge clk); #1;
      if (idx != 0) mregs[idx] = data;
      bus.write = 1'b0;
   endtask

   task automatic setop(input logic [4:0] r1, input logic [4:0] r2, input logic src,
                        input logic [31:0] imm, input logic [3:0] op);
      bus.readReg1 = r1; bus.readReg2 = r2; bus.alu_src = src; bus.imm = imm; bus.alu_op = op;
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] a, b, r;
      a = (bus.readReg1 == 0) ? 32'h0 : mregs[bus.readReg1];
      b = (bus.readReg2 == 0) ? 32'h0 : mregs[bus.readReg2];
      r = ref_alu(bus.alu_op, a, bus.alu_src ? bus.imm : b);
      check({tag, ".rd1"}, bus.readData1, a);
      check({tag, ".rd2"}, bus.readData2, b);
      check({tag, ".res"}, bus.result, r);
      check({tag, ".zero"}, {31'h0, bus.zero}, {31'h0, r == 32'h0});
   endtask

   initial begin
      checks = 0; errors = 0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      rst = 1'b1;
      bus.readReg1 = 5'd0; bus.readReg2 = 5'd0; bus.writeReg = 5'd0; bus.writeData = 32'h0;
      bus.write = 1'b0; bus.alu_src = 1'b0; bus.imm = 32'h0; bus.alu_op = 4'b0010;
      #12;
      check("reset.rd1", bus.readData1, 32'h0);
      check("reset.res", bus.result, 32'h0);
      check("reset.zero", {31'h0, bus.zero}, 32'h1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset pulsed between edges wipes x5.
      wr(5'd5, 32'hDEAD_BEEF);
      setop(5'd5, 5'd0, 1'b0, 32'h0, 4'b0010);
      check("pre_rst.x5", bus.readData1, 32'hDEAD_BEEF);
      #2 rst = 1'b1; #1;
      check("async_rst.x5", bus.readData1, 32'h0);
      rst = 1'b0;
      mregs[5] = 32'h0;

      // A write across an edge while rst is held is dropped.
      bus.write = 1'b1; bus.writeReg = 5'd6; bus.writeData = 32'h5555_AAAA;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.write = 1'b0; rst = 1'b0;
      setop(5'd6, 5'd0, 1'b0, 32'h0, 4'b0010);
      check("rst_write.x6", bus.readData1, 32'h0);

      wr(5'd0, 32'h1234);
      setop(5'd0, 5'd0, 1'b0, 32'h0, 4'b0010);
      check("x0.rd1", bus.readData1, 32'h0);

      wr(5'd1, 32'd7); wr(5'd2, 32'd7);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0010);
      check("add.res", bus.result, 32'd14);
      check("add.zero", {31'h0, bus.zero}, 32'h0);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0110);
      check("sub.res", bus.result, 32'd0);
      check("sub.zero", {31'h0, bus.zero}, 32'h1);
      wr(5'd1, 32'hFFFF_FFFF);
      setop(5'd1, 5'd0, 1'b1, 32'h1, 4'b0010);
      check("add_wrap.res", bus.result, 32'h0);
      check("add_wrap.zero", {31'h0, bus.zero}, 32'h1);

      wr(5'd1, 32'h8000_0010);
      setop(5'd1, 5'd0, 1'b1, 32'h24, 4'b1000);
      check("srl.res", bus.result, 32'h0800_0001);
      setop(5'd1, 5'd0, 1'b1, 32'h24, 4'b1010);
      check("sra.res", bus.result, 32'hF800_0001);
      setop(5'd1, 5'd0, 1'b1, 32'h24, 4'b1001);
      check("sll.res", bus.result, 32'h0000_0100);

      wr(5'd1, 32'hFFFF_FFFF); wr(5'd2, 32'd1);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0111);
      check("slt.res", bus.result, 32'd1);
      setop(5'd2, 5'd1, 1'b0, 32'h0, 4'b0111);
      check("slt_swap.res", bus.result, 32'd0);

      wr(5'd1, 32'hF0F0_F0F0); wr(5'd2, 32'h0FF0_0FF0);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0000);
      check("and.res", bus.result, 32'h00F0_00F0);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0001);
      check("or.res", bus.result, 32'hFFF0_FFF0);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b1101);
      check("xor.res", bus.result, 32'hFF00_FF00);
      setop(5'd1, 5'd2, 1'b0, 32'h0, 4'b0011);
      check("undef.res", bus.result, 32'h0);
      check("undef.zero", {31'h0, bus.zero}, 32'h1);

      wr(5'd3, 32'd10);
      bus.write = 1'b1; bus.writeReg = 5'd3; bus.writeData = 32'd20;
      setop(5'd3, 5'd0, 1'b0, 32'h0, 4'b0010);
      check("rdw.before", bus.readData1, 32'd10);
      @(posedge clk); #1;
      bus.write = 1'b0; mregs[3] = 32'd20;
      check("rdw.after", bus.readData1, 32'd20);

      // Random traffic: outputs are checked before each edge against pre-write model state.
      for (int n = 0; n < 300; n++) begin
         bus.write     = 1'($urandom);
         bus.writeReg  = 5'($urandom);
         bus.writeData = (($urandom % 4) == 0) ? 32'h0 : $urandom;
         setop(5'($urandom), 5'($urandom), 1'($urandom), $urandom, 4'($urandom));
         check_model("rand");
         @(posedge clk); #1;
         if (bus.write && bus.writeReg != 0) mregs[bus.writeReg] = bus.writeData;
      end
      bus.write = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
